// File: rtl/approx_mul_error_monitor_if.sv
// rtl/approx_mul_error_monitor_if.sv - bundle of sweep control, multiplier and result signals
//
// Purpose: groups everything between the error monitor and its environment.
//   master modport: the monitor (drives operands and results, consumes start/product)
//   slave modport : the environment (drives start and product, observes the rest)
// Signals:
//   start    sweep request           busy/done  sweep status
//   a_o/b_o  operands to multiplier  approx_i   product from multiplier
//   max_err/err_cnt/sum_err/viol/fail_idx       accumulated results
interface approx_mul_error_monitor_if #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 4,
  parameter int CNT_W = 16,
  parameter int SUM_W = 24
);
  logic                start;
  logic [IN_W-1:0]     a_o;
  logic [IN_W-1:0]     b_o;
  logic [OUT_W-1:0]    approx_i;
  logic                busy;
  logic                done;
  logic [OUT_W-1:0]    max_err;
  logic [CNT_W-1:0]    err_cnt;
  logic [SUM_W-1:0]    sum_err;
  logic                viol;
  logic [2*IN_W-1:0]   fail_idx;

  modport master (
    input  start, approx_i,
    output a_o, b_o, busy, done, max_err, err_cnt, sum_err, viol, fail_idx
  );

  modport slave (
    output start, approx_i,
    input  a_o, b_o, busy, done, max_err, err_cnt, sum_err, viol, fail_idx
  );
endinterface

// File: rtl/approx_mul_error_monitor.sv
// rtl/approx_mul_error_monitor.sv - exhaustive error characterisation of an approximate multiplier
//
// Purpose: sweeps every {b,a} operand pair into a combinational approximate
//   multiplier, compares each product against the exact product and
//   accumulates max |error|, nonzero-error count, error sum, and a sticky
//   threshold violation with the index of the first violating pair.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   approx_mul_error_monitor_if.master (start, a_o, b_o, approx_i,
//         busy, done, max_err, err_cnt, sum_err, viol, fail_idx)
module approx_mul_error_monitor #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 4,
  parameter int ET    = 4,
  parameter int CNT_W = 16,
  parameter int SUM_W = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  approx_mul_error_monitor_if.master  bus
);
  localparam int IDX_W = 2 * IN_W;

  if (OUT_W != 2 * IN_W) begin : g_bad_width
    $error("approx_mul_error_monitor: OUT_W must equal 2*IN_W");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [OUT_W-1:0] ET_V = OUT_W'(ET);

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic              drain_cnt;

  // stage 1 registers
  logic              v1;
  logic [OUT_W-1:0]  s1_approx;
  logic [OUT_W-1:0]  s1_exact;
  logic [IDX_W-1:0]  s1_idx;

  // results
  logic [OUT_W-1:0]  max_err;
  logic [CNT_W-1:0]  err_cnt;
  logic [SUM_W-1:0]  sum_err;
  logic              viol;
  logic [IDX_W-1:0]  fail_idx;

  logic              sweeping;
  logic [IN_W-1:0]   a_c;
  logic [IN_W-1:0]   b_c;
  logic [OUT_W-1:0]  exact_c;
  logic [OUT_W-1:0]  err_c;
  logic [SUM_W:0]    sum_ext;

  assign sweeping = (state == S_SWEEP);

  // operands are forced to zero outside the sweep so the multiplier sees a quiet bus
  assign a_c = sweeping ? idx[IN_W-1:0]     : '0;
  assign b_c = sweeping ? idx[IDX_W-1:IN_W] : '0;

  assign exact_c = {{(OUT_W-IN_W){1'b0}}, a_c} * {{(OUT_W-IN_W){1'b0}}, b_c};

  // absolute difference without wrap
  assign err_c = (s1_exact >= s1_approx) ? (s1_exact - s1_approx)
                                         : (s1_approx - s1_exact);

  // one extra bit catches the carry used for saturation
  assign sum_ext = {1'b0, sum_err} + {{(SUM_W+1-OUT_W){1'b0}}, err_c};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      drain_cnt <= 1'b0;
      v1        <= 1'b0;
      s1_approx <= '0;
      s1_exact  <= '0;
      s1_idx    <= '0;
      max_err   <= '0;
      err_cnt   <= '0;
      sum_err   <= '0;
      viol      <= 1'b0;
      fail_idx  <= '0;
    end else begin
      v1 <= sweeping;
      if (sweeping) begin
        s1_approx <= bus.approx_i;
        s1_exact  <= exact_c;
        s1_idx    <= idx;
      end

      if (v1) begin
        if (err_c > max_err) max_err <= err_c;
        if (err_c != '0 && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        sum_err <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        if (err_c > ET_V && !viol) begin
          viol     <= 1'b1;
          fail_idx <= s1_idx;
        end
      end

      case (state)
        S_IDLE: begin
          // v1 is always low here, so clearing cannot race an accumulation
          if (bus.start) begin
            idx      <= '0;
            max_err  <= '0;
            err_cnt  <= '0;
            sum_err  <= '0;
            viol     <= 1'b0;
            fail_idx <= '0;
            state    <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          idx <= idx + 1'b1;
          if (idx == '1) begin
            drain_cnt <= 1'b0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.a_o      = a_c;
  assign bus.b_o      = b_c;
  assign bus.busy     = sweeping || (state == S_DRAIN);
  assign bus.done     = (state == S_DONE);
  assign bus.max_err  = max_err;
  assign bus.err_cnt  = err_cnt;
  assign bus.sum_err  = sum_err;
  assign bus.viol     = viol;
  assign bus.fail_idx = fail_idx;
endmodule

// File: tb/tb_approx_mul_error_monitor.sv
// tb/tb_approx_mul_error_monitor.sv - randomized self-checking bench for approx_mul_error_monitor
module tb_approx_mul_error_monitor;
  localparam int IN_W  = 2;
  localparam int OUT_W = 4;
  localparam int ET    = 4;
  localparam int SUM_W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   mode = 0;
  logic [3:0] rand_tab [16];

  int errors = 0;
  int checks = 0;

  int exp_max, exp_cnt, exp_sum, exp_viol, exp_fidx;

  always #5 clk = ~clk;

  approx_mul_error_monitor_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(16), .SUM_W(SUM_W)) bus_a ();
  approx_mul_error_monitor_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(2),  .SUM_W(SUM_W)) bus_b ();

  // stub multiplier: 0 exact, 1 zero, 2 LSB cleared, otherwise random table
  function automatic logic [3:0] stub(input int m, input logic [1:0] a, input logic [1:0] b);
    int p;
    p = int'(a) * int'(b);
    case (m)
      0:       return 4'(p);
      1:       return 4'd0;
      2:       return 4'(p - (p % 2));
      default: return rand_tab[{b, a}];
    endcase
  endfunction

  assign bus_a.start    = start;
  assign bus_b.start    = start;
  assign bus_a.approx_i = stub(mode, bus_a.a_o, bus_a.b_o);
  assign bus_b.approx_i = stub(mode, bus_b.a_o, bus_b.b_o);

  approx_mul_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET), .CNT_W(16), .SUM_W(SUM_W)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  approx_mul_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET), .CNT_W(2), .SUM_W(SUM_W)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference: walk all pairs in sweep order and apply the accumulation rules
  task automatic model();
    int e;
    exp_max = 0; exp_cnt = 0; exp_sum = 0; exp_viol = 0; exp_fidx = 0;
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 4; a++) begin
        e = a * b - int'(stub(mode, 2'(a), 2'(b)));
        if (e < 0) e = -e;
        if (e > exp_max) exp_max = e;
        if (e != 0) exp_cnt++;
        exp_sum += e;
        if (e > ET && exp_viol == 0) begin
          exp_viol = 1;
          exp_fidx = b * 4 + a;
        end
      end
    end
  endtask

  task automatic check_results(input string tag);
    chk({tag, " max_err"},  bus_a.max_err,  exp_max);
    chk({tag, " err_cnt"},  bus_a.err_cnt,  exp_cnt);
    chk({tag, " sum_err"},  bus_a.sum_err,  exp_sum);
    chk({tag, " viol"},     bus_a.viol,     exp_viol);
    chk({tag, " fail_idx"}, bus_a.fail_idx, exp_fidx);
    chk({tag, " sat err_cnt"}, bus_b.err_cnt, (exp_cnt > 3) ? 3 : exp_cnt);
    chk({tag, " sat max_err"}, bus_b.max_err, exp_max);
    chk({tag, " sat sum_err"}, bus_b.sum_err, exp_sum);
    chk({tag, " sat fail_idx"}, bus_b.fail_idx, exp_fidx);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " busy"},     bus_a.busy,     0);
    chk({tag, " done"},     bus_a.done,     0);
    chk({tag, " max_err"},  bus_a.max_err,  0);
    chk({tag, " err_cnt"},  bus_a.err_cnt,  0);
    chk({tag, " sum_err"},  bus_a.sum_err,  0);
    chk({tag, " viol"},     bus_a.viol,     0);
    chk({tag, " fail_idx"}, bus_a.fail_idx, 0);
    chk({tag, " a_o"},      bus_a.a_o,      0);
    chk({tag, " b_o"},      bus_a.b_o,      0);
  endtask

  // start is accepted at the edge ending cycle 0; cycle k is sampled at the
  // negedge after k further edges. poke asserts start again during that cycle.
  task automatic run_sweep(input string tag, input int poke);
    int done_cyc;
    model();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy at cycle 1"}, bus_a.busy, 1);
    done_cyc = 1;
    while (!bus_a.done && done_cyc < 60) begin
      start = (done_cyc == poke);
      @(negedge clk);
      start = 1'b0;
      done_cyc++;
    end
    chk({tag, " done cycle"}, done_cyc, 19);
    chk({tag, " busy in done"}, bus_a.busy, 0);
    @(negedge clk);
    chk({tag, " done width"}, bus_a.done, 0);
    repeat (3) @(negedge clk);
    check_results(tag);
  endtask

  initial begin
    int saw_done;

    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    mode = 0; run_sweep("exact", 0);
    mode = 1; run_sweep("zero", 0);
    mode = 2; run_sweep("lsb", 0);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) rand_tab[i] = 4'($urandom_range(0, 15));
      mode = 3;
      run_sweep($sformatf("rand%0d", r), 0);
    end
    mode = 1; run_sweep("poke", 5);

    // reset during cycle 8 of a zero-stub sweep
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("midrst");
    saw_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus_a.done) saw_done = 1;
    end
    chk("midrst no done", saw_done, 0);
    run_sweep("after rst", 0);

    // reset and start together: reset wins
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check_cleared("rst+start");
    saw_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus_a.done || bus_a.busy) saw_done = 1;
    end
    chk("rst+start idle", saw_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
